lelbc_iter_core: RTL
====================

// Module: lelbc_iter_core
// PURPOSE
//  Parametrised, handshaked successor of the LELBC iterative cipher datapath.
//  Loads one block and a master key, then applies ROUNDS iterations of the shared
//  round function, one round per clock. The result is returned on a valid/ready port.
//  Adds encrypt/decrypt mode, back-pressure, abort, and back-to-back operation.
//  Sits between the host-side block FIFO and the output formatter.
// PARAMETERS
//  BLK_W    64   block width in bits (multiple of 16)
//  KEY_W    128  key width in bits (multiple of BLK_W)
//  ROUNDS   16   number of round iterations (2..31)
//  CNT_W    5    round counter width; must satisfy 2**CNT_W > ROUNDS
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      block/key/mode on in_* are valid
//  in_ready   out  1      core can accept a block this cycle
//  in_data    in   BLK_W  plaintext (enc) or ciphertext (dec)
//  in_key     in   KEY_W  master key (enc) or final-round key (dec)
//  in_dec     in   1      0 = encrypt, 1 = decrypt
//  abort      in   1      synchronous cancel of the operation in flight
//  out_valid  out  1      out_data holds a finished result
//  out_ready  in   1      consumer takes the result this cycle
//  out_data   out  BLK_W  result block
//  busy       out  1      high in RUN
// BEHAVIOUR
//  Reset (async, any state):
//   - FSM=IDLE; cnt=0; state/key/out_data regs=0; out_valid=0; busy=0.
//   - in_ready is 1 once rst deasserts.
//  FSM: IDLE, RUN, DONE.
//   - in_ready = (IDLE) | (DONE & out_ready). This is combinational from FSM and out_ready.
//   - Accept edge (in_valid & in_ready):
//     - st<=in_data; rk<=in_key; dec<=in_dec; cnt<=0; FSM->RUN.
//   - RUN, each edge:
//     - st,rk <= round_fn(st, rk, idx, dec), where idx = dec ? ROUNDS-1-cnt : cnt.
//     - cnt<=cnt+1.
//     - On the edge with cnt==ROUNDS-1: out_data<=new st; out_valid<=1; FSM->DONE.
//   - Latency: out_valid rises exactly ROUNDS cycles after the accept edge.
//   - DONE: out_data and out_valid are held stable while out_ready=0.
//   - out_valid & out_ready:
//     - If in_valid is also high: accept the new block on the same edge (FSM->RUN, out_valid<=0).
//     - Otherwise: FSM->IDLE, out_valid<=0.
//     - Throughput is one block per ROUNDS+1 cycles.
//  abort:
//   - Sampled only in RUN: FSM->IDLE, cnt<=0, out_valid stays 0, no result is produced.
//   - Ignored in IDLE and DONE. The result in DONE is never dropped by abort.
//  in_valid in RUN is ignored (in_ready=0). The upstream holds its data.
//  cnt never exceeds ROUNDS-1. Wrap is not possible by construction.
//  Decrypt: the caller supplies the final-round key. round_fn applies the inverse
//  layers and the inverse key update, so dec(enc(P,K), Klast) = P.
//  Reset mid-RUN: the operation is lost and the FSM returns to IDLE. The host must resubmit.
// STRUCTURE
//  Package lelbc_pkg:
//   - BLK_W/KEY_W defaults, S-box and inverse S-box tables, permutation constants,
//     round-constant table indexed by round.
//   - Typedef-equivalent width macros.
//  Sub-module lelbc_round_fn:
//   - Purely combinational.
//   - Inputs (st, rk, idx, dec); outputs (st_nx, rk_nx).
//   - Shared with future unrolled/pipelined variants.
//  Top holds FSM, counter, registers and handshake only.
// TESTING
//  1. Reset, then one encrypt: in_data=64'h0, in_key=128'h0, out_ready=1.
//     -> out_valid exactly 16 cycles after accept.
//     -> out_data == golden C model; in_ready low during RUN.
//  2. Round-trip: encrypt 64'h0123456789ABCDEF under key 128'h000102..0F, then decrypt
//     with the final-round key.
//     -> out_data == 64'h0123456789ABCDEF.
//  3. Back-pressure: out_ready=0 for 10 cycles after out_valid.
//     -> out_data stable, in_ready=0.
//     -> Raise out_ready with in_valid=1: new block accepted on the same edge,
//        next out_valid 16 cycles later.
//  4. Abort: assert abort on RUN cycle 7.
//     -> next cycle FSM=IDLE, in_ready=1, no out_valid pulse.
//     -> A following block completes correctly.
//  5. Async reset at RUN cycle 9 (mid-cycle pulse).
//     -> outputs reach reset values without a clock edge.
//     -> After release, a fresh block completes correctly.
//  6. ROUNDS=4, BLK_W=32, KEY_W=64 build.
//     -> latency 4 cycles; results match the golden model for 1000 random blocks and keys.

Source files
------------

// File: rtl/lelbc_pkg.sv
// Shared constants for the LELBC cipher family: S-boxes, bit permutation,
// round constants and the control FSM encoding.
package lelbc_pkg;

    localparam int BLK_W_DEF  = 64;
    localparam int KEY_W_DEF  = 128;
    localparam int ROUNDS_DEF = 16;
    localparam int CNT_W_DEF  = 5;

    // Key register rotation per round, in bits.
    localparam int KEY_ROT = 16;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    localparam logic [7:0] RC [32] = '{
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3E, 8'h3D, 8'h3B,
        8'h37, 8'h2F, 8'h1E, 8'h3C, 8'h39, 8'h33, 8'h27, 8'h0E,
        8'h1D, 8'h3A, 8'h35, 8'h2B, 8'h16, 8'h2C, 8'h18, 8'h30,
        8'h21, 8'h02, 8'h05, 8'h0B, 8'h17, 8'h2E, 8'h1C, 8'h38
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    // Bit j of the substituted block moves to this position; the top bit is fixed.
    function automatic int perm_pos(input int j, input int n);
        return (j == n - 1) ? j : (j * (n / 4)) % (n - 1);
    endfunction

endpackage

// File: rtl/lelbc_round_fn.sv
// One LELBC round, forward or inverse, as pure combinational logic.
// Decrypt undoes the key update first, then strips the layers with that key.
module lelbc_round_fn
    import lelbc_pkg::*;
#(
    parameter int BLK_W = BLK_W_DEF,
    parameter int KEY_W = KEY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [BLK_W-1:0] st,
    input  logic [KEY_W-1:0] rk,
    input  logic [CNT_W-1:0] idx,
    input  logic             dec,
    output logic [BLK_W-1:0] st_nx,
    output logic [KEY_W-1:0] rk_nx
);

    logic [BLK_W-1:0] x, sub, perm, iperm, isub;
    logic [KEY_W-1:0] k_rot, k_fwd, t_inv, k_inv;
    logic [4:0]       rc_idx;

    assign rc_idx = 5'(idx);
    assign x      = st ^ rk[BLK_W-1:0];

    for (genvar i = 0; i < BLK_W / 4; i++) begin : g_sbox
        assign sub[4*i +: 4]  = SBOX[x[4*i +: 4]];
        assign isub[4*i +: 4] = SBOX_INV[iperm[4*i +: 4]];
    end

    for (genvar j = 0; j < BLK_W; j++) begin : g_perm
        localparam int DST = perm_pos(j, BLK_W);
        assign perm[DST] = sub[j];
        assign iperm[j]  = st[DST];
    end

    // Forward key update: rotate left, substitute top nibble, mix round constant.
    assign k_rot = {rk[KEY_W-KEY_ROT-1:0], rk[KEY_W-1:KEY_W-KEY_ROT]};
    assign k_fwd = {SBOX[k_rot[KEY_W-1 -: 4]], k_rot[KEY_W-5:8], k_rot[7:0] ^ RC[rc_idx]};
    assign t_inv = {SBOX_INV[rk[KEY_W-1 -: 4]], rk[KEY_W-5:8], rk[7:0] ^ RC[rc_idx]};
    assign k_inv = {t_inv[KEY_ROT-1:0], t_inv[KEY_W-1:KEY_ROT]};

    assign st_nx = dec ? (isub ^ k_inv[BLK_W-1:0]) : perm;
    assign rk_nx = dec ? k_inv : k_fwd;

endmodule

// File: rtl/lelbc_iter_core.sv
// Iterative LELBC core: one round per clock, valid/ready on both sides,
// encrypt/decrypt, abort, and back-to-back accept from DONE.
module lelbc_iter_core
    import lelbc_pkg::*;
#(
    parameter int BLK_W  = BLK_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_dec,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    fsm_t             fsm;
    logic [BLK_W-1:0] st, st_nx;
    logic [KEY_W-1:0] rk, rk_nx;
    logic [CNT_W-1:0] cnt, idx;
    logic             dec;
    logic             accept;

    // NOTE: in_ready is combinational so a result can be drained and a new block taken on one edge.
    assign in_ready = (fsm == S_IDLE) || ((fsm == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (fsm == S_RUN);
    assign idx      = dec ? (LAST - cnt) : cnt;

    lelbc_round_fn #(.BLK_W(BLK_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) u_round (
        .st    (st),
        .rk    (rk),
        .idx   (idx),
        .dec   (dec),
        .st_nx (st_nx),
        .rk_nx (rk_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            cnt       <= '0;
            st        <= '0;
            rk        <= '0;
            dec       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (accept) begin
                        st  <= in_data;
                        rk  <= in_key;
                        dec <= in_dec;
                        cnt <= '0;
                        fsm <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        cnt <= '0;
                        fsm <= S_IDLE;
                    end else begin
                        st <= st_nx;
                        rk <= rk_nx;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            out_data  <= st_nx;
                            out_valid <= 1'b1;
                            fsm       <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st  <= in_data;
                            rk  <= in_key;
                            dec <= in_dec;
                            cnt <= '0;
                            fsm <= S_RUN;
                        end else begin
                            fsm <= S_IDLE;
                        end
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule
